// File: rtl/seq_det_stream_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_stream_ctrl_pkg
// Shared definitions for the sequence-detector stream controller.
//   - state_t   : controller FSM state codes (2-bit)
//   - DEF_WIDTH : default number of bits per frame
//   - DEF_CNT_W : default width of the saturating match counter
// No ports; imported by the interface and the top level.
// -----------------------------------------------------------------------------
package seq_det_stream_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_det_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_det_stream_ctrl_if
// Bundles the requester and detector signals of the stream controller.
//   req       : level requests, one bit per requester
//   data0/1   : frames for requester 0 / 1
//   grant     : one-hot owner of the detector
//   det_clr   : synchronous clear for the detector
//   x_out     : serial bit into the detector, x_valid qualifies it
//   z_in      : Mealy output of the detector for the current x_out
//   busy/done : controller status, done is a one-cycle pulse
//   match_cnt : number of z pulses seen in the last frame
// Modports: slave = controller side, master = requester/detector side.
// -----------------------------------------------------------------------------
interface seq_det_stream_ctrl_if
    import seq_det_stream_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic [1:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [1:0]       grant;
    logic             det_clr;
    logic             x_out;
    logic             x_valid;
    logic             z_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    modport slave (
        input  req, data0, data1, z_in,
        output grant, det_clr, x_out, x_valid, busy, done, match_cnt
    );

    modport master (
        output req, data0, data1, z_in,
        input  grant, det_clr, x_out, x_valid, busy, done, match_cnt
    );

endinterface

// File: rtl/mealy_10101.sv
// -----------------------------------------------------------------------------
// mealy_10101
// Overlapping Mealy detector for the serial pattern 1-0-1-0-1.
//   clk   : clock, rising edge
//   reset : synchronous active-high clear of the pattern history
//   x     : serial input bit
//   z     : high combinationally while the current x completes 10101
// -----------------------------------------------------------------------------
module mealy_10101 (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic z
);

    // Each state names the longest suffix seen so far that is also a prefix
    // of the target pattern.
    typedef enum logic [2:0] {
        S_NONE  = 3'd0,
        S_1     = 3'd1,
        S_10    = 3'd2,
        S_101   = 3'd3,
        S_1010  = 3'd4
    } det_state_t;

    det_state_t state_q, state_d;

    // History register, cleared synchronously.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transition table. A hit from 1010 falls back to 101 so that
    // overlapping occurrences are all reported.
    always_comb begin
        state_d = S_NONE;
        z       = 1'b0;
        case (state_q)
            S_NONE: state_d = x ? S_1   : S_NONE;
            S_1:    state_d = x ? S_1   : S_10;
            S_10:   state_d = x ? S_101 : S_NONE;
            S_101:  state_d = x ? S_1   : S_1010;
            S_1010: begin
                state_d = x ? S_101 : S_NONE;
                z       = x;
            end
            default: state_d = S_NONE;
        endcase
    end

endmodule

// File: rtl/seq_det_stream_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   req_i : request vector
//   ptr_i : favoured requester when both request (0 or 1)
//   en_i  : arbitration allowed this cycle
//   gnt_o : one-hot grant (zero when disabled or no request)
//   ptr_o : pointer to load when the grant is taken
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);

    // Pick a single owner. A lone request always wins; with both requesting
    // the pointer decides. After any grant the pointer swings to the side that
    // was not served so a requester holding its line cannot starve the other.
    always_comb begin
        gnt_o = 2'b00;
        ptr_o = ptr_i;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
            if (gnt_o[0]) begin
                ptr_o = 1'b1;
            end else if (gnt_o[1]) begin
                ptr_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_stream_ctrl
// Shares one serial sequence detector between two requesters. The owner is
// picked round-robin, the detector is cleared for one cycle, the owner's word
// is shifted out MSB-first and z pulses are counted (saturating). done pulses
// for one cycle with the count valid.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : seq_det_stream_ctrl_if.slave (req, data0/1, z_in in;
//           grant, det_clr, x_out, x_valid, busy, done, match_cnt out)
// -----------------------------------------------------------------------------
module seq_det_stream_ctrl
    import seq_det_stream_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_det_stream_ctrl_if.slave  bus
);

    localparam int               BIT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               ptr_q, ptr_d;

    logic [1:0]         arb_gnt;
    logic               arb_ptr;
    logic               arb_en;

    // New owners are only chosen from IDLE; requests changing during a frame
    // have no effect until the controller is free again.
    assign arb_en = (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (arb_gnt),
        .ptr_o (arb_ptr)
    );

    // All controller state lives here. Reset drops any frame in flight
    // without a done pulse; the detector itself is cleared by the next CLEAR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            ptr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    // Frame sequencing: IDLE -> CLEAR (one cycle) -> SHIFT (WIDTH cycles)
    // -> DONE (one cycle) -> IDLE. z_in is only counted at the end of a SHIFT
    // cycle because it is a Mealy output of the bit currently on x_out.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        match_cnt_d = match_cnt_q;
        ptr_d       = ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    grant_d = arb_gnt;
                    shreg_d = arb_gnt[1] ? bus.data1 : bus.data0;
                    ptr_d   = arb_ptr;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                match_cnt_d = '0;
                bit_cnt_d   = LAST_BIT;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bus.z_in && (match_cnt_q != CNT_MAX)) begin
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                end
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                if (bit_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end
            end
            ST_DONE: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state so they are glitch-free and
    // x_out is forced low whenever it is not qualified.
    assign bus.grant     = grant_q;
    assign bus.det_clr   = (state_q == ST_CLEAR);
    assign bus.x_valid   = (state_q == ST_SHIFT);
    assign bus.x_out     = (state_q == ST_SHIFT) & shreg_q[WIDTH-1];
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_stream_ctrl
// Directed bench for seq_det_stream_ctrl driving a real mealy_10101 detector.
// A second instance with a 1-bit match counter covers saturation.
// -----------------------------------------------------------------------------
module tb_seq_det_stream_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    seq_det_stream_ctrl_if #(.WIDTH(8), .CNT_W(4)) bus ();
    seq_det_stream_ctrl_if #(.WIDTH(8), .CNT_W(1)) bus5 ();

    seq_det_stream_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seq_det_stream_ctrl #(.WIDTH(8), .CNT_W(1)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    mealy_10101 det (
        .clk   (clk),
        .reset (reset | bus.det_clr),
        .x     (bus.x_out),
        .z     (bus.z_in)
    );

    mealy_10101 det5 (
        .clk   (clk),
        .reset (reset | bus5.det_clr),
        .x     (bus5.x_out),
        .z     (bus5.z_in)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame on the main instance: waits (bounded) for CLEAR, checks
    // the owner and the lead-in length, every serial bit, then the done cycle.
    task automatic applyStimulus(input string tag, input logic [1:0] reqV,
                                 input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [1:0] expGrant, input int expCnt,
                                 input int expLead, input bit dropReq);
        int         lead;
        logic [7:0] frame;
        bus.req   = reqV;
        bus.data0 = d0;
        bus.data1 = d1;
        lead = 0;
        do begin
            tick();
            lead++;
        end while (!bus.det_clr && lead < 6);
        checkOutput({tag, ".lead"}, lead, expLead);
        checkOutput({tag, ".grant"}, {30'd0, bus.grant}, {30'd0, expGrant});
        checkOutput({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
        frame = expGrant[1] ? d1 : d0;
        for (int i = 7; i >= 0; i--) begin
            tick();
            checkOutput({tag, ".xbit"}, {30'd0, bus.x_valid, bus.x_out}, {30'd0, 1'b1, frame[i]});
        end
        tick();
        checkOutput({tag, ".done"}, {31'd0, bus.done}, 32'd1);
        checkOutput({tag, ".cnt"}, {28'd0, bus.match_cnt}, expCnt);
        checkOutput({tag, ".grant_done"}, {30'd0, bus.grant}, {30'd0, expGrant});
        if (dropReq) begin
            bus.req = 2'b00;
        end
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        bus.req    = 2'b00;
        bus.data0  = 8'h00;
        bus.data1  = 8'h00;
        bus5.req   = 2'b00;
        bus5.data0 = 8'h00;
        bus5.data1 = 8'h00;
        tick();
        tick();

        // Reset state.
        checkOutput("rst.grant", {30'd0, bus.grant}, 32'd0);
        checkOutput("rst.busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst.done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst.cnt", {28'd0, bus.match_cnt}, 32'd0);
        checkOutput("rst.xv_xo", {30'd0, bus.x_valid, bus.x_out}, 32'd0);
        checkOutput("rst.det_clr", {31'd0, bus.det_clr}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: requester 0, two overlapping matches.
        applyStimulus("t1", 2'b01, 8'hAA, 8'h00, 2'b01, 2, 1, 1'b1);
        tick();
        checkOutput("t1.done_pulse", {31'd0, bus.done}, 32'd0);
        checkOutput("t1.idle", {31'd0, bus.busy}, 32'd0);
        checkOutput("t1.grant_drop", {30'd0, bus.grant}, 32'd0);
        checkOutput("t1.cnt_held", {28'd0, bus.match_cnt}, 32'd2);

        // 2: requester 1, all ones, no matches.
        applyStimulus("t2", 2'b10, 8'h00, 8'hFF, 2'b10, 0, 1, 1'b1);
        tick();
        checkOutput("t2.done_pulse", {31'd0, bus.done}, 32'd0);
        checkOutput("t2.idle", {31'd0, bus.busy}, 32'd0);

        // 3: both held, grants alternate with a single idle cycle between frames.
        applyStimulus("t3a", 2'b11, 8'hAA, 8'hF0, 2'b01, 2, 1, 1'b0);
        applyStimulus("t3b", 2'b11, 8'hAA, 8'hF0, 2'b10, 0, 2, 1'b0);
        applyStimulus("t3c", 2'b11, 8'hAA, 8'hF0, 2'b01, 2, 2, 1'b1);
        tick();

        // 4: first frame leaves the detector one bit from a match;
        //    the clear must stop it from matching on the next frame.
        applyStimulus("t4a", 2'b01, 8'h0A, 8'h00, 2'b01, 0, 1, 1'b0);
        applyStimulus("t4b", 2'b01, 8'h80, 8'h00, 2'b01, 0, 2, 1'b1);
        tick();

        // 6: reset three cycles into SHIFT aborts the frame.
        bus.req   = 2'b01;
        bus.data0 = 8'hAA;
        tick();
        checkOutput("t6.clear", {31'd0, bus.det_clr}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t6.shift", {31'd0, bus.x_valid}, 32'd1);
        end
        reset   = 1'b1;
        bus.req = 2'b00;
        tick();
        checkOutput("t6.grant", {30'd0, bus.grant}, 32'd0);
        checkOutput("t6.busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("t6.done", {31'd0, bus.done}, 32'd0);
        checkOutput("t6.xv_xo", {30'd0, bus.x_valid, bus.x_out}, 32'd0);
        checkOutput("t6.det_clr", {31'd0, bus.det_clr}, 32'd0);
        checkOutput("t6.cnt", {28'd0, bus.match_cnt}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("t6.no_done", {31'd0, bus.done}, 32'd0);
        end
        // Pointer is back to favouring requester 0 after reset.
        applyStimulus("t6n", 2'b11, 8'hAA, 8'hF0, 2'b01, 2, 1, 1'b1);
        tick();

        // 5: 1-bit counter saturates at 1 despite two matches.
        bus5.req   = 2'b01;
        bus5.data0 = 8'hAA;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus5.done && n < 30);
        checkOutput("t5.cycles", n, 32'd10);
        checkOutput("t5.sat", {31'd0, bus5.match_cnt}, 32'd1);
        checkOutput("t5.grant", {30'd0, bus5.grant}, 32'd1);
        bus5.req = 2'b00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
